// File: rtl/idac_pkg.sv
// rtl/idac_pkg.sv - shared types and constants for the current-DAC sweep sequencer
//
// Purpose : state encoding and DAC code constants used by idac_sweep_ctrl.
// Contents: IDAC_WIDTH, IDAC_IDLE_CODE, idac_state_t (IDLE, RUN).
package idac_pkg;

    localparam int                    IDAC_WIDTH     = 8;
    localparam logic [IDAC_WIDTH-1:0] IDAC_IDLE_CODE = 8'hFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } idac_state_t;

endpackage

// File: rtl/idac_dwell_cnt.sv
// rtl/idac_dwell_cnt.sv - loadable down-counter flagging the final count of a dwell
//
// Purpose : holds the number of cycles remaining in a dwell; last_o is a
//           registered flag that is high during the final cycle.
// Ports   : clk_i, reset_i (sync, active-high), load_i, value_i[W-1:0], last_o.
// Loading 0 parks the counter with last_o low until the next load.
module idac_dwell_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         last_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         last_q, last_d;

    // last is computed one cycle ahead so it can be presented as a flop.
    always_comb begin
        cnt_d  = cnt_q;
        last_d = 1'b0;
        if (load_i) begin
            cnt_d  = value_i;
            last_d = (value_i == W'(1));
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - W'(1);
            last_d = (cnt_q == W'(2));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/idac_sweep_ctrl.sv
// rtl/idac_sweep_ctrl.sv - start/stop/step code sweep sequencer for the 8-bit current DAC
//
// Purpose : steps ib from a start code to a stop code, holding each code for a
//           programmed dwell and pulsing sample on the last dwell cycle.
// Ports   : clk_i, reset_i (sync, active-high), start_i, abort_i, code_start_i,
//           code_stop_i, step_i, dwell_i, loop_i -> ib_o, busy_o, sample_o, done_o.
module idac_sweep_ctrl
    import idac_pkg::*;
#(
    parameter int               WIDTH     = IDAC_WIDTH,
    parameter int               DWELL_W   = 16,
    parameter logic [WIDTH-1:0] IDLE_CODE = IDAC_IDLE_CODE
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [WIDTH-1:0]   code_start_i,
    input  logic [WIDTH-1:0]   code_stop_i,
    input  logic [WIDTH-1:0]   step_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic               loop_i,
    output logic [WIDTH-1:0]   ib_o,
    output logic               busy_o,
    output logic               sample_o,
    output logic               done_o
);

    idac_state_t        state_q, state_d;
    logic [WIDTH-1:0]   ib_q, ib_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   start_q, start_d;
    logic [WIDTH-1:0]   stop_q, stop_d;
    logic [WIDTH-1:0]   step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               loop_q, loop_d;
    logic               up_q, up_d;

    logic               cnt_load;
    logic [DWELL_W-1:0] cnt_value;
    logic               cnt_last;

    logic [WIDTH:0]     sum_up, sum_dn;
    logic [WIDTH-1:0]   next_code;

    idac_dwell_cnt #(.W(DWELL_W)) u_dwell (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (cnt_load),
        .value_i (cnt_value),
        .last_o  (cnt_last)
    );

    // One extra bit catches both overflow above the top code and borrow
    // below zero; either case, or overshooting stop, clamps to stop.
    always_comb begin
        sum_up = {1'b0, ib_q} + {1'b0, step_q};
        sum_dn = {1'b0, ib_q} - {1'b0, step_q};
        if (up_q) begin
            next_code = (sum_up > {1'b0, stop_q}) ? stop_q : sum_up[WIDTH-1:0];
        end else begin
            next_code = (sum_dn[WIDTH] || (sum_dn[WIDTH-1:0] < stop_q)) ? stop_q
                                                                       : sum_dn[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        ib_d      = ib_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        start_d   = start_q;
        stop_d    = stop_q;
        step_d    = step_q;
        dwell_d   = dwell_q;
        loop_d    = loop_q;
        up_d      = up_q;
        cnt_load  = 1'b0;
        cnt_value = dwell_q;

        if (abort_i) begin
            // Parking the counter at 0 keeps a stale dwell from raising sample in IDLE.
            state_d   = IDLE;
            ib_d      = IDLE_CODE;
            busy_d    = 1'b0;
            cnt_load  = 1'b1;
            cnt_value = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        start_d   = code_start_i;
                        stop_d    = code_stop_i;
                        step_d    = (step_i == '0) ? WIDTH'(1) : step_i;
                        dwell_d   = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
                        loop_d    = loop_i;
                        up_d      = (code_stop_i >= code_start_i);
                        ib_d      = code_start_i;
                        busy_d    = 1'b1;
                        state_d   = RUN;
                        cnt_load  = 1'b1;
                        cnt_value = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
                    end
                end
                RUN: begin
                    if (cnt_last) begin
                        if (ib_q != stop_q) begin
                            ib_d     = next_code;
                            cnt_load = 1'b1;
                        end else if (loop_q) begin
                            ib_d     = start_q;
                            cnt_load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    ib_d    = IDLE_CODE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ib_q    <= IDLE_CODE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= WIDTH'(1);
            dwell_q <= DWELL_W'(1);
            loop_q  <= 1'b0;
            up_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            ib_q    <= ib_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            loop_q  <= loop_d;
            up_q    <= up_d;
        end
    end

    assign ib_o     = ib_q;
    assign busy_o   = busy_q;
    assign sample_o = cnt_last;
    assign done_o   = done_q;

endmodule
